// File: rtl/mem_uart_dump_if.sv
// Memory read port plus UART byte handshake between the dump engine and its neighbours.
interface mem_uart_dump_if #(
  parameter int unsigned ADDR_W = 4
) ();
  logic [ADDR_W-1:0] dump_addr;
  logic [15:0]       dump_data;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  // master = dump engine, slave = memory read port + UART transmitter side
  modport master (
    output dump_addr,
    output tx_data,
    output tx_valid,
    input  dump_data,
    input  tx_ready
  );

  modport slave (
    input  dump_addr,
    input  tx_data,
    input  tx_valid,
    output dump_data,
    output tx_ready
  );
endinterface

// File: rtl/mem_uart_dump.sv
// Walks data memory 0..DEPTH-1, streams each word high byte first to the UART,
// optionally followed by a CRC-8 (poly 0x07, init 0x00, MSB first) of all data bytes.
module mem_uart_dump #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 16,
  parameter bit          CRC_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  mem_uart_dump_if.master bus,
  output logic            busy,
  output logic            done,
  output logic [7:0]      crc_out
);
  localparam int unsigned       BYTE_W    = 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [BYTE_W-1:0] CRC_POLY  = 8'h07;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND_HI,
    SEND_LO,
    SEND_CRC,
    FINISH
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [BYTE_W-1:0]   crc_q, crc_d;
  logic                xfer_c;
  logic [BYTE_W-1:0]   crc_upd_c;

  // One full byte of CRC-8 update, unrolled into a single combinational step
  function automatic logic [BYTE_W-1:0] crc8_byte(input logic [BYTE_W-1:0] crc,
                                                  input logic [BYTE_W-1:0] data);
    logic [BYTE_W-1:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

  // The byte on tx_data_q is the one being transferred, so the CRC folds it in
  assign xfer_c    = tx_valid_q & bus.tx_ready;
  assign crc_upd_c = crc8_byte(crc_q, tx_data_q);

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      word_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      crc_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      crc_q      <= crc_d;
    end
  end

  // Next-state and next-output logic; everything holds unless a transfer advances it
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    word_d     = word_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    crc_d      = crc_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          addr_d  = '0;
          crc_d   = '0;
          busy_d  = 1'b1;
        end
      end
      FETCH: begin
        word_d     = DATA_W'(bus.dump_data);
        tx_data_d  = bus.dump_data[15:8];
        tx_valid_d = 1'b1;
        state_d    = SEND_HI;
      end
      SEND_HI: begin
        if (xfer_c) begin
          crc_d     = crc_upd_c;
          tx_data_d = word_q[7:0];
          state_d   = SEND_LO;
        end
      end
      SEND_LO: begin
        if (xfer_c) begin
          crc_d = crc_upd_c;
          if (addr_q == LAST_ADDR) begin
            if (CRC_EN) begin
              tx_data_d = crc_upd_c;
              state_d   = SEND_CRC;
            end else begin
              tx_valid_d = 1'b0;
              busy_d     = 1'b0;
              done_d     = 1'b1;
              state_d    = FINISH;
            end
          end else begin
            addr_d     = addr_q + ADDR_W'(1);
            tx_valid_d = 1'b0;
            state_d    = FETCH;
          end
        end
      end
      SEND_CRC: begin
        if (xfer_c) begin
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d    = IDLE;
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  assign bus.dump_addr = addr_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_valid  = tx_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign crc_out       = crc_q;

endmodule

// File: tb/tb_mem_uart_dump.sv
// Directed bench: a 16-word dump without CRC and a 1-word dump with CRC.
module tb_mem_uart_dump;
  localparam int unsigned AW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start16, start1;
  logic        rdy16, rdy1;
  logic [15:0] mem16 [16];
  logic [15:0] mem1;
  logic        busy16, done16, busy1, done1;
  logic [7:0]  crc16, crc1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done16_cnt = 0, done1_cnt = 0, busy16_cnt = 0;
  logic [7:0] q16[$];
  logic [7:0] q1[$];

  mem_uart_dump_if #(.ADDR_W(AW)) bus16 ();
  mem_uart_dump_if #(.ADDR_W(AW)) bus1 ();

  assign bus16.dump_data = mem16[bus16.dump_addr];
  assign bus16.tx_ready  = rdy16;
  assign bus1.dump_data  = mem1;
  assign bus1.tx_ready   = rdy1;

  mem_uart_dump #(.DEPTH(16), .ADDR_W(AW), .DATA_W(16), .CRC_EN(1'b0)) u_dut16 (
    .clk(clk), .reset(reset), .start(start16), .bus(bus16),
    .busy(busy16), .done(done16), .crc_out(crc16));

  mem_uart_dump #(.DEPTH(1), .ADDR_W(AW), .DATA_W(16), .CRC_EN(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .bus(bus1),
    .busy(busy1), .done(done1), .crc_out(crc1));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte capture and pulse counting, sampled mid-cycle
  always @(negedge clk) begin
    if (bus16.tx_valid && rdy16) q16.push_back(bus16.tx_data);
    if (bus1.tx_valid && rdy1)   q1.push_back(bus1.tx_data);
    if (done16) done16_cnt <= done16_cnt + 1;
    if (done1)  done1_cnt  <= done1_cnt + 1;
    if (busy16) busy16_cnt <= busy16_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done16();
    int n = 0;
    while (done16 !== 1'b1 && n < 400) begin
      wait_cycle();
      n++;
    end
    check("done16_seen", 32'(done16), 32'd1);
  endtask

  task automatic wait_done1();
    int n = 0;
    while (done1 !== 1'b1 && n < 50) begin
      wait_cycle();
      n++;
    end
    check("done1_seen", 32'(done1), 32'd1);
  endtask

  task automatic wait_addr16(input logic [3:0] a);
    int n = 0;
    while (!(bus16.dump_addr === a && bus16.tx_valid === 1'b1) && n < 200) begin
      wait_cycle();
      n++;
    end
    check("addr16_reached", 32'(bus16.dump_addr), 32'(a));
  endtask

  task automatic check_stream16(input string tag, input int base);
    logic [15:0] w;
    logic [7:0]  e;
    logic [7:0]  o;
    check({tag, "_len"}, 32'(q16.size() - base), 32'd32);
    for (int j = 0; j < 32; j++) begin
      w = mem16[4'(j / 2)];
      e = (j % 2 == 0) ? w[15:8] : w[7:0];
      o = (base + j < q16.size()) ? q16[base + j] : 8'hxx;
      check($sformatf("%s_b%0d", tag, j), 32'(o), 32'(e));
    end
  endtask

  initial begin
    int base, t0, d0, b0;
    reset = 1'b0;
    start16 = 1'b0;
    start1 = 1'b0;
    rdy16 = 1'b1;
    rdy1 = 1'b1;
    mem1 = 16'h0100;
    for (int i = 0; i < 16; i++) mem16[i] = 16'(i);

    // Reset values before any clock edge
    #3;
    check("rst_addr", 32'(bus16.dump_addr), 32'd0);
    check("rst_txdata", 32'(bus16.tx_data), 32'd0);
    check("rst_valid", 32'(bus16.tx_valid), 32'd0);
    check("rst_busy", 32'(busy16), 32'd0);
    check("rst_done", 32'(done16), 32'd0);
    check("rst_crc", 32'(crc16), 32'd0);
    check("rst_valid1", 32'(bus1.tx_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    wait_cycle();

    // Plain 16-word dump of mem[i]=i
    base = q16.size();
    d0 = done16_cnt;
    b0 = busy16_cnt;
    start16 = 1'b1;
    wait_cycle();
    start16 = 1'b0;
    t0 = cyc;
    check("r1_busy_start", 32'(busy16), 32'd1);
    check("r1_valid_fetch", 32'(bus16.tx_valid), 32'd0);
    check("r1_addr_start", 32'(bus16.dump_addr), 32'd0);
    wait_done16();
    check("r1_latency", 32'(cyc - t0), 32'd48);
    check("r1_busy_fin", 32'(busy16), 32'd0);
    check("r1_valid_fin", 32'(bus16.tx_valid), 32'd0);
    check("r1_addr_last", 32'(bus16.dump_addr), 32'd15);
    wait_cycle();
    check("r1_done_pulse", 32'(done16), 32'd0);
    check("r1_done_count", 32'(done16_cnt - d0), 32'd1);
    check("r1_busy_cycles", 32'(busy16_cnt - b0), 32'd48);
    check("r1_addr_hold", 32'(bus16.dump_addr), 32'd15);
    check_stream16("r1", base);

    // Backpressure at word 3, ignored restart at word 7, patched word 5
    mem16[5] = 16'hABCD;
    base = q16.size();
    d0 = done16_cnt;
    start16 = 1'b1;
    wait_cycle();
    start16 = 1'b0;
    t0 = cyc;
    wait_addr16(4'd3);
    rdy16 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_cycle();
      check($sformatf("bp_valid_%0d", k), 32'(bus16.tx_valid), 32'd1);
      check($sformatf("bp_data_%0d", k), 32'(bus16.tx_data), 32'h00);
      check($sformatf("bp_addr_%0d", k), 32'(bus16.dump_addr), 32'd3);
    end
    rdy16 = 1'b1;
    wait_addr16(4'd7);
    start16 = 1'b1;
    wait_cycle();
    start16 = 1'b0;
    check("r2_busy_after_restart", 32'(busy16), 32'd1);
    check("r2_addr_after_restart", 32'(bus16.dump_addr), 32'd7);
    wait_done16();
    check("r2_latency", 32'(cyc - t0), 32'd53);
    wait_cycle();
    check("r2_done_count", 32'(done16_cnt - d0), 32'd1);
    check_stream16("r2", base);
    check("r2_byte10", 32'((base + 10 < q16.size()) ? q16[base + 10] : 8'hxx), 32'hAB);
    check("r2_byte11", 32'((base + 11 < q16.size()) ? q16[base + 11] : 8'hxx), 32'hCD);

    // Asynchronous reset in the middle of word 9
    d0 = done16_cnt;
    start16 = 1'b1;
    wait_cycle();
    start16 = 1'b0;
    wait_addr16(4'd9);
    #2;
    reset = 1'b0;
    #1;
    check("mr_addr", 32'(bus16.dump_addr), 32'd0);
    check("mr_txdata", 32'(bus16.tx_data), 32'd0);
    check("mr_valid", 32'(bus16.tx_valid), 32'd0);
    check("mr_busy", 32'(busy16), 32'd0);
    check("mr_done", 32'(done16), 32'd0);
    check("mr_crc", 32'(crc16), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    wait_cycle();
    check("mr_no_done", 32'(done16_cnt - d0), 32'd0);
    base = q16.size();
    start16 = 1'b1;
    wait_cycle();
    start16 = 1'b0;
    check("mr_restart_addr", 32'(bus16.dump_addr), 32'd0);
    check("mr_restart_crc", 32'(crc16), 32'd0);
    wait_done16();
    wait_cycle();
    check_stream16("mr", base);

    // One word with CRC: 0x0100 -> 01 00 15
    base = q1.size();
    d0 = done1_cnt;
    start1 = 1'b1;
    wait_cycle();
    start1 = 1'b0;
    t0 = cyc;
    check("c1_crc_clear", 32'(crc1), 32'd0);
    wait_done1();
    check("c1_latency", 32'(cyc - t0), 32'd4);
    check("c1_crc_final", 32'(crc1), 32'h15);
    check("c1_addr", 32'(bus1.dump_addr), 32'd0);
    start1 = 1'b1;
    wait_cycle();
    start1 = 1'b0;
    check("c1_start_in_finish", 32'(busy1), 32'd0);
    wait_cycle();
    check("c1_still_idle", 32'(busy1), 32'd0);
    check("c1_crc_hold", 32'(crc1), 32'h15);
    check("c1_done_count", 32'(done1_cnt - d0), 32'd1);
    check("c1_len", 32'(q1.size() - base), 32'd3);
    check("c1_b0", 32'((base + 0 < q1.size()) ? q1[base + 0] : 8'hxx), 32'h01);
    check("c1_b1", 32'((base + 1 < q1.size()) ? q1[base + 1] : 8'hxx), 32'h00);
    check("c1_b2", 32'((base + 2 < q1.size()) ? q1[base + 2] : 8'hxx), 32'h15);

    // One word with CRC: 0x0001 -> 00 01 07, CRC must restart from 0
    mem1 = 16'h0001;
    base = q1.size();
    start1 = 1'b1;
    wait_cycle();
    start1 = 1'b0;
    check("c2_crc_clear", 32'(crc1), 32'd0);
    wait_done1();
    check("c2_crc_final", 32'(crc1), 32'h07);
    wait_cycle();
    check("c2_len", 32'(q1.size() - base), 32'd3);
    check("c2_b0", 32'((base + 0 < q1.size()) ? q1[base + 0] : 8'hxx), 32'h00);
    check("c2_b1", 32'((base + 1 < q1.size()) ? q1[base + 1] : 8'hxx), 32'h01);
    check("c2_b2", 32'((base + 2 < q1.size()) ? q1[base + 2] : 8'hxx), 32'h07);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
